// File: rtl/cmp_trace_uart.sv
// cmp_trace_uart: captures compare-sample records {err_flags, romc, db, emu_db},
// queues them in a small FIFO, and sends each one as four 8N1 UART bytes on uart_tx.
// Ports: clk/rst (async, active-high); sample/capture_all/err_flags/romc/db/emu_db form the capture side;
// clear zeroes overflow and drop_cnt. Outputs: uart_tx (idle high), busy, overflow (sticky),
// drop_cnt (saturating at 255), level (records held in the FIFO).
module cmp_trace_uart #(
  parameter int CLKS_PER_BIT = 174,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample,
  input  logic                  capture_all,
  input  logic [4:0]            err_flags,
  input  logic [4:0]            romc,
  input  logic [7:0]            db,
  input  logic [7:0]            emu_db,
  input  logic                  clear,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [25:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic [25:0]         r_rec;
  logic [1:0]          r_byte_idx, w_byte_idx_nxt;
  logic [2:0]          r_bit_idx, w_bit_idx_nxt;
  logic [15:0]         r_timer, w_timer_nxt;
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;
  logic                w_empty, w_full, w_push_req, w_push, w_pop, w_drop;
  logic [7:0]          w_byte;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                      (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_push_req = sample && (capture_all || (|err_flags));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  assign level    = r_wr_ptr - r_rd_ptr;
  assign busy     = !w_empty || (r_state != IDLE);
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  // Storage has no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {err_flags, romc, db, emu_db};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rec      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rec    <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      end
      // A drop in the same cycle as clear wins: the drop is the first one counted.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clear)                    r_drop_cnt <= 8'd1;
        else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (clear) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= 8'd0;
      end
    end
  end

  // Byte 0 carries the 3'b101 sync marker the host aligns on.
  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      2'd0:    w_byte = {3'b101, r_rec[25:21]};
      2'd1:    w_byte = {3'b000, r_rec[20:16]};
      2'd2:    w_byte = r_rec[15:8];
      default: w_byte = r_rec[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd0;
      r_timer    <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  // Bit timer counts down from CLKS_PER_BIT-1 and is reloaded at every bit boundary.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_bit_idx_nxt  = r_bit_idx;
    w_timer_nxt    = r_timer;
    w_pop          = 1'b0;
    uart_tx        = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_byte_idx_nxt = 2'd0;
          w_timer_nxt    = BIT_RELOAD;
          w_state_nxt    = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (r_timer == 16'd0) begin
          w_timer_nxt   = BIT_RELOAD;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = DATA;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      DATA: begin
        uart_tx = w_byte[r_bit_idx];
        if (r_timer == 16'd0) begin
          w_timer_nxt = BIT_RELOAD;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      STOP: begin
        if (r_timer == 16'd0) begin
          w_timer_nxt = BIT_RELOAD;
          if (r_byte_idx == 2'd3) begin
            w_state_nxt = IDLE;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_state_nxt    = START;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
